// File: rtl/d_sram_like_slave.sv
// rtl/d_sram_like_slave.sv - data-side sram-like bus responder driving a 1-cycle-latency block RAM
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req, wr, size, addr      request from the initiator (size: 0 byte, 1 half, 2/3 word)
//   wdata                    write data, lanes already replicated
//   rdata                    read data, valid whenever data_ok is high for a read
//   addr_ok                  request accepted this cycle (IDLE and not in reset)
//   data_ok                  one-cycle completion pulse
//   ram_en, ram_wen          RAM enable and byte write enables (active only in ACCESS)
//   ram_addr, ram_wdata      latched word address and write data
//   ram_rdata                RAM read data, valid the cycle after a read access
module d_sram_like_slave #(
    parameter int RAM_AW = 14,
    parameter int DELAY  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [3:0] DELAY_CNT = 4'(DELAY);

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_wr;
    logic [RAM_AW-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       rdata_q;
    // High during the single cycle in which the RAM presents read data.
    logic              cap;

    // Address bits above the RAM capacity are ignored, so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:RAM_AW+2];

    function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            2'd0:    be = 4'b0001 << a;
            2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    assign addr_ok   = (state == IDLE) & ~rst;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    // In the capture cycle the RAM output is forwarded so that a DELAY of 0
    // still presents valid data alongside data_ok; rdata_q takes the same
    // value at the end of that cycle and holds it afterwards.
    assign rdata     = cap ? ram_rdata : rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            cap       <= 1'b0;
            data_ok   <= 1'b0;
            ram_en    <= 1'b0;
            ram_wen   <= 4'b0000;
        end else begin
            data_ok <= 1'b0;
            ram_en  <= 1'b0;
            ram_wen <= 4'b0000;
            cap     <= 1'b0;
            if (cap) begin
                rdata_q <= ram_rdata;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_wr    <= wr;
                        lat_addr  <= addr[RAM_AW+1:2];
                        lat_wdata <= wdata;
                        ram_en    <= 1'b1;
                        ram_wen   <= wr ? byte_enables(size, addr[1:0]) : 4'b0000;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    cap <= ~lat_wr;
                    if (DELAY == 0) begin
                        state   <= RESP;
                        data_ok <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= DELAY_CNT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Counter reaches zero at this edge: next cycle is RESP.
                    if (cnt == 4'd1) begin
                        state   <= RESP;
                        data_ok <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_sram_like_slave.sv
// tb/tb_d_sram_like_slave.sv - directed self-checking bench for d_sram_like_slave
module tb_d_sram_like_slave;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic [3:0]          addr_ok_v;
    logic [3:0]          data_ok_v;
    logic [3:0]          ram_en_v;
    logic [3:0][31:0]    rdata_v;
    logic [3:0][3:0]     ram_wen_v;
    logic [3:0][AW-1:0]  ram_addr_v;

    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Four instances: index 0..3 have DELAY 0, 2, 4, 5, each with its own RAM.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [31:0] mem [2**AW];
        logic [31:0] rd;
        logic [31:0] wd;

        d_sram_like_slave #(
            .RAM_AW (AW),
            .DELAY  (g == 0 ? 0 : g == 1 ? 2 : g == 2 ? 4 : 5)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req       (req),
            .wr        (wr),
            .size      (size),
            .addr      (addr),
            .wdata     (wdata),
            .rdata     (rdata_v[g]),
            .addr_ok   (addr_ok_v[g]),
            .data_ok   (data_ok_v[g]),
            .ram_en    (ram_en_v[g]),
            .ram_wen   (ram_wen_v[g]),
            .ram_addr  (ram_addr_v[g]),
            .ram_wdata (wd),
            .ram_rdata (rd)
        );

        always @(posedge clk) begin
            if (pl_en) begin
                mem[pl_addr] <= pl_data;
            end else if (ram_en_v[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wen_v[g][b]) mem[ram_addr_v[g]][8*b +: 8] <= wd[8*b +: 8];
                end
                if (ram_wen_v[g] == 4'b0000) rd <= mem[ram_addr_v[g]];
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Presents a request to instance idx when it is idle; returns at the
    // negedge of cycle T+1 (the ACCESS cycle) with req dropped.
    task automatic issue(input int idx, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (addr_ok_v[idx] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL issue_timeout idx %0d addr_ok %b required 1", idx, addr_ok_v[idx]);
        end
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic test_reset;
        preload(8'd4, 32'hDEADBEEF);
        preload(8'd8, 32'h11112222);
        preload(8'd5, 32'hCAFEF00D);
        preload(8'd6, 32'h0BADF00D);
        checks++;
        if (addr_ok_v !== 4'h0 || data_ok_v !== 4'h0 || ram_en_v !== 4'h0) begin
            errors++;
            $display("FAIL reset_ctrl got aok %b dok %b en %b required 0000 each", addr_ok_v, data_ok_v, ram_en_v);
        end
        checks++;
        if (ram_wen_v !== '0 || rdata_v !== '0 || ram_addr_v !== '0) begin
            errors++;
            $display("FAIL reset_data got wen %h rdata %h raddr %h required 0", ram_wen_v, rdata_v, ram_addr_v);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (addr_ok_v !== 4'hF) begin
            errors++;
            $display("FAIL reset_release_aok got %b required 1111", addr_ok_v);
        end
        issue(1, 1'b0, 2'd2, 32'h10, 32'd0);
        checks++;
        if (ram_en_v[1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_async_en got %b required 1", ram_en_v[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ram_en_v !== 4'h0 || addr_ok_v !== 4'h0 || ram_wen_v !== '0) begin
            errors++;
            $display("FAIL async_reset got en %b aok %b wen %h required 0", ram_en_v, addr_ok_v, ram_wen_v);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_read;
        issue(1, 1'b0, 2'd2, 32'h10, 32'd0);
        checks++;
        if (ram_en_v[1] !== 1'b1 || ram_addr_v[1] !== 8'd4 || ram_wen_v[1] !== 4'b0000 || addr_ok_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL read_access got en %b addr %0d wen %b aok %b required 1 4 0000 0",
                     ram_en_v[1], ram_addr_v[1], ram_wen_v[1], addr_ok_v[1]);
        end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (addr_ok_v[1] !== 1'b0 || data_ok_v[1] !== (k == 4)) begin
                errors++;
                $display("FAIL read_cycle_T+%0d got aok %b dok %b required 0 %b", k, addr_ok_v[1], data_ok_v[1], k == 4);
            end
        end
        checks++;
        if (rdata_v[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_rdata got %h required deadbeef", rdata_v[1]);
        end
        @(negedge clk);
        checks++;
        if (addr_ok_v[1] !== 1'b1 || data_ok_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL read_back_idle got aok %b dok %b required 1 0", addr_ok_v[1], data_ok_v[1]);
        end
    endtask

    task automatic test_byte_half_write;
        int dok;
        issue(1, 1'b1, 2'd0, 32'h13, 32'hAAAAAAAA);
        checks++;
        if (ram_wen_v[1] !== 4'b1000 || ram_addr_v[1] !== 8'd4) begin
            errors++;
            $display("FAIL byte_wen got wen %b addr %0d required 1000 4", ram_wen_v[1], ram_addr_v[1]);
        end
        dok = 0;
        repeat (4) begin @(negedge clk); dok += int'(data_ok_v[1]); end
        checks++;
        if (dok != 1 || rdata_v[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL byte_resp got dok %0d rdata %h required 1 deadbeef", dok, rdata_v[1]);
        end
        issue(1, 1'b1, 2'd1, 32'h22, 32'h55555555);
        checks++;
        if (ram_wen_v[1] !== 4'b1100 || ram_addr_v[1] !== 8'd8) begin
            errors++;
            $display("FAIL half_wen got wen %b addr %0d required 1100 8", ram_wen_v[1], ram_addr_v[1]);
        end
        dok = 0;
        repeat (4) begin @(negedge clk); dok += int'(data_ok_v[1]); end
        checks++;
        if (dok != 1 || rdata_v[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL half_resp got dok %0d rdata %h required 1 deadbeef", dok, rdata_v[1]);
        end
        issue(1, 1'b0, 2'd2, 32'h10, 32'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (data_ok_v[1] !== 1'b1 || rdata_v[1] !== 32'hAAADBEEF) begin
            errors++;
            $display("FAIL byte_merge got dok %b rdata %h required 1 aaadbeef", data_ok_v[1], rdata_v[1]);
        end
        issue(1, 1'b0, 2'd2, 32'h20, 32'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (data_ok_v[1] !== 1'b1 || rdata_v[1] !== 32'h55552222) begin
            errors++;
            $display("FAIL half_merge got dok %b rdata %h required 1 55552222", data_ok_v[1], rdata_v[1]);
        end
    endtask

    task automatic test_back_to_back;
        issue(0, 1'b1, 2'd2, 32'h40, 32'h12345678);
        checks++;
        if (ram_en_v[0] !== 1'b1 || ram_wen_v[0] !== 4'b1111 || ram_addr_v[0] !== 8'd16) begin
            errors++;
            $display("FAIL b2b_write got en %b wen %b addr %0d required 1 1111 16", ram_en_v[0], ram_wen_v[0], ram_addr_v[0]);
        end
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h40;
        @(negedge clk);
        checks++;
        if (data_ok_v[0] !== 1'b1 || addr_ok_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_write_dok got dok %b aok %b required 1 0", data_ok_v[0], addr_ok_v[0]);
        end
        @(negedge clk);
        checks++;
        if (addr_ok_v[0] !== 1'b1 || data_ok_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got aok %b dok %b required 1 0", addr_ok_v[0], data_ok_v[0]);
        end
        @(negedge clk);
        checks++;
        if (ram_en_v[0] !== 1'b1 || ram_wen_v[0] !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_read_access got en %b wen %b required 1 0000", ram_en_v[0], ram_wen_v[0]);
        end
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (data_ok_v[0] !== 1'b1 || rdata_v[0] !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_read got dok %b rdata %h required 1 12345678", data_ok_v[0], rdata_v[0]);
        end
    endtask

    task automatic test_busy_reject;
        int n = 0;
        int aok, dok, en, dok_k;
        logic [31:0] rd_seen;
        @(negedge clk);
        while (addr_ok_v[3] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        aok = int'(addr_ok_v[3]);
        dok = 0; en = 0; dok_k = -1; rd_seen = 32'd0;
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h14;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            aok += int'(addr_ok_v[3]);
            dok += int'(data_ok_v[3]);
            en  += int'(ram_en_v[3]);
            if (data_ok_v[3] === 1'b1) begin dok_k = k; rd_seen = rdata_v[3]; end
        end
        req = 1'b0;
        checks++;
        if (aok != 1 || dok != 1 || en != 1) begin
            errors++;
            $display("FAIL busy_counts got aok %0d dok %0d en %0d required 1 1 1", aok, dok, en);
        end
        checks++;
        if (dok_k != 7 || rd_seen !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL busy_resp got cycle %0d rdata %h required 7 cafef00d", dok_k, rd_seen);
        end
        @(negedge clk);
        checks++;
        if (addr_ok_v[3] !== 1'b1 || ram_en_v[3] !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle got aok %b en %b required 1 0", addr_ok_v[3], ram_en_v[3]);
        end
    endtask

    task automatic test_reset_mid_wait;
        int dok;
        issue(2, 1'b0, 2'd2, 32'h18, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rdata_v[2] !== 32'd0 || data_ok_v[2] !== 1'b0 || addr_ok_v[2] !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset got rdata %h dok %b aok %b required 0 0 0", rdata_v[2], data_ok_v[2], addr_ok_v[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        dok = 0;
        repeat (8) begin @(negedge clk); dok += int'(data_ok_v[2]); end
        checks++;
        if (dok != 0 || rdata_v[2] !== 32'd0) begin
            errors++;
            $display("FAIL midwait_dropped got dok %0d rdata %h required 0 0", dok, rdata_v[2]);
        end
        issue(2, 1'b0, 2'd2, 32'h18, 32'd0);
        repeat (5) @(negedge clk);
        checks++;
        if (data_ok_v[2] !== 1'b1 || rdata_v[2] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL midwait_recover got dok %b rdata %h required 1 0badf00d", data_ok_v[2], rdata_v[2]);
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_half_write();
        test_back_to_back();
        test_busy_reject();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/d_sram_like_slave.md
Name: d_sram_like_slave

Overview:
Responder end of the data-side sram-like bus. It accepts one request at a time from the CPU-side initiator (req/addr_ok, then data_ok) and executes that request on a synchronous single-port block RAM with 1-cycle read latency. A programmable response delay lets the same block stand in for slow memory during core bring-up and verification.

Parameters:
RAM_AW, 14, word-address width of the attached RAM (capacity 2^RAM_AW 32-bit words)
DELAY, 2, extra wait cycles before data_ok (0..15)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req  input  1  sram-like request
wr  input  1  1 = write, 0 = read
size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word
addr  input  32  byte address
wdata  input  32  write data, lanes already replicated by the initiator
rdata  output  32  registered read data
addr_ok  output  1  address/request accepted
data_ok  output  1  transaction complete, one-cycle pulse
ram_en  output  1  RAM enable
ram_wen  output  4  RAM byte write enables
ram_addr  output  RAM_AW  RAM word address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, valid the cycle after ram_en with ram_wen=0

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. Only one transaction is outstanding at a time.
- addr_ok = (state==IDLE) & ~rst. It is combinational. It is 0 in ACCESS, WAIT and RESP.
- Handshake: when req & addr_ok is seen at edge T:
  - latch wr, size, addr and wdata;
  - the state becomes ACCESS during cycle T+1.
- req seen while not in IDLE is ignored. The initiator must hold req until accepted.
- ACCESS (exactly 1 cycle):
  - ram_en=1 and ram_addr = latched addr[RAM_AW+1:2].
  - Addresses wrap modulo 2^(RAM_AW+2) bytes.
  - ram_wdata = latched wdata.
- ram_wen, for writes only (0000 for reads):
  - size 0: 0001 << addr[1:0];
  - size 1: addr[1] ? 1100 : 0011 (addr[0] ignored);
  - size 2 or 3: 1111.
- After ACCESS:
  - if DELAY==0, go to RESP;
  - otherwise go to WAIT with a 4-bit counter loaded to DELAY.
- Read capture: in the first cycle after ACCESS (the first WAIT cycle, or RESP when DELAY==0), rdata <= ram_rdata.
- WAIT: the counter decrements each cycle. When it reaches 0 the next state is RESP.
- RESP (1 cycle): data_ok=1. The next state is IDLE.
- Timing:
  - data_ok is asserted in cycle T+2+DELAY.
  - The earliest next handshake is at edge T+3+DELAY.
  - addr_ok and data_ok are never high in the same cycle.
- rdata:
  - updates only on read transactions and holds its value across writes and idle time;
  - always carries the full 32-bit word; the initiator selects lanes;
  - is valid whenever data_ok=1 for a read.
- Outputs outside ACCESS: ram_en=0 and ram_wen=0000. ram_addr and ram_wdata hold their latched values.
- Reset (asynchronous, at any time, including mid-transaction):
  - state=IDLE, counter=0, rdata=0, data_ok=0, ram_en=0, ram_wen=0;
  - latched request fields are cleared to 0;
  - addr_ok=0 while rst is high;
  - an in-flight transaction is dropped and no data_ok is produced for it.
- Write-then-read to the same address returns the merged new data. The RAM write completes in ACCESS, before any later read.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge → all outputs are 0 immediately. Release rst → addr_ok=1.
- Word read, DELAY=2:
  - stimulus: RAM[4]=0xDEADBEEF; req=1, wr=0, size=2, addr=0x10 accepted at edge T;
  - response: ram_en=1 with ram_addr=4 in T+1; data_ok=1 in T+4 with rdata=0xDEADBEEF; addr_ok=0 during T+1..T+4.
- Byte and halfword writes:
  - byte: wr=1, size=0, addr=0x13, wdata=0xAAAAAAAA → ram_wen=1000, ram_addr=4; RAM[4] becomes 0xAAADBEEF;
  - halfword: size=1, addr=0x22 → ram_wen=1100;
  - in both cases data_ok pulses once and rdata is unchanged.
- Back-to-back, DELAY=0:
  - stimulus: write word 0x12345678 to addr 0x40, then a read of 0x40 with req held high;
  - response: write data_ok at T+2; read accepted at T+3; read data_ok at T+5 with rdata=0x12345678.
- Busy rejection: req held high throughout a DELAY=5 read → exactly one addr_ok and one data_ok per transaction; no duplicate RAM access.
- Reset mid-WAIT: assert rst during a DELAY=4 read → no data_ok and rdata=0. The next read after release completes normally.
